// File: rtl/simple_linear_fifo_core.sv
// simple_linear_fifo_core
// Single-clock synchronous FIFO. DATA_WIDTH-bit words are buffered in a
// circular store of FIFO_DEPTH entries. Read data is registered, and EMPTY
// and FULL flags are provided.
//
// Optional feature macro: FIFO_COUNT_EN. When it is defined, the COUNT
// occupancy port is present.
//
// Ports
//   FCLK      in   1                single clock, rising edge
//   FRSTN     in   1                synchronous reset, ACTIVE-HIGH
//                                  (1 = reset at the next FCLK rise)
//   WR_EN     in   1                write request
//   RD_EN     in   1                read request
//   DATA_IN   in   DATA_WIDTH       write data
//   DATA_OUT  out  DATA_WIDTH       registered read data (1-cycle latency)
//   EMPTY     out  1                no stored entries
//   FULL      out  1                FIFO_DEPTH stored entries
//   COUNT     out  ADDR_WIDTH+1     occupancy (FIFO_COUNT_EN only)
//
// Handshake
//   WR_EN and RD_EN act as the "valid" side, and ~FULL / ~EMPTY act as the
//   "ready" side. A transfer happens at a rising FCLK edge only when the
//   request is high and the matching flag allows it:
//     wr_acc = WR_EN & ~FULL
//     rd_acc = RD_EN & ~EMPTY
//   Both flags come from the pre-edge state. A request that is not accepted
//   has no effect at all. Because there is no bypass path, a word written
//   into an empty FIFO can be read one cycle later at the earliest.

module simple_linear_fifo_core #(
  parameter  int DATA_WIDTH = 8,
  parameter  int FIFO_DEPTH = 16,  // power of two, >= 2
  localparam int ADDR_WIDTH = $clog2(FIFO_DEPTH)
) (
  input  logic                  FCLK,
  input  logic                  FRSTN,
  input  logic                  WR_EN,
  input  logic                  RD_EN,
  input  logic [DATA_WIDTH-1:0] DATA_IN,
  output logic [DATA_WIDTH-1:0] DATA_OUT,
  output logic                  EMPTY,
`ifdef FIFO_COUNT_EN
  output logic [ADDR_WIDTH:0]   COUNT,
`endif
  output logic                  FULL
);

  localparam logic [ADDR_WIDTH:0] PTR_ONE = (ADDR_WIDTH + 1)'(1);

  // The pointers carry one extra wrap bit above the index bits. This lets
  // the design tell full (same index, different lap) from empty (identical
  // pointers).
  logic [ADDR_WIDTH:0]   wr_ptr_q, wr_ptr_d;
  logic [ADDR_WIDTH:0]   rd_ptr_q, rd_ptr_d;
  logic [DATA_WIDTH-1:0] data_out_q, data_out_d;
  logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];

  logic empty, full, wr_acc, rd_acc;

  always_comb begin
    empty      = (wr_ptr_q == rd_ptr_q);
    full       = (wr_ptr_q[ADDR_WIDTH-1:0] == rd_ptr_q[ADDR_WIDTH-1:0]) &&
                 (wr_ptr_q[ADDR_WIDTH] != rd_ptr_q[ADDR_WIDTH]);
    wr_acc     = WR_EN & ~full;
    rd_acc     = RD_EN & ~empty;

    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    data_out_d = data_out_q;
    if (wr_acc) begin
      wr_ptr_d = wr_ptr_q + PTR_ONE;
    end
    if (rd_acc) begin
      rd_ptr_d   = rd_ptr_q + PTR_ONE;
      data_out_d = mem_q[rd_ptr_q[ADDR_WIDTH-1:0]];
    end
  end

  always_ff @(posedge FCLK) begin
    if (FRSTN) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      data_out_q <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      data_out_q <= data_out_d;
    end
  end

  // The storage array has no reset. After a reset the contents are
  // unreachable, because both pointers are back at zero.
  always_ff @(posedge FCLK) begin
    if (!FRSTN && wr_acc) begin
      mem_q[wr_ptr_q[ADDR_WIDTH-1:0]] <= DATA_IN;
    end
  end

  assign DATA_OUT = data_out_q;
  assign EMPTY    = empty;
  assign FULL     = full;

`ifdef FIFO_COUNT_EN
  // The modulo difference of the wrap-extended pointers is the occupancy,
  // which ranges from 0 to FIFO_DEPTH.
  assign COUNT = wr_ptr_q - rd_ptr_q;
`endif

endmodule

// File: tb/tb_simple_linear_fifo_core.sv
// tb_simple_linear_fifo_core
// Self-checking bench for simple_linear_fifo_core, using the default
// parameters (8-bit data, 16 entries).
//
// - A reference queue models the FIFO contents.
// - At each rising edge, the model process applies the accept rules to the
//   inputs that were driven. It pushes the expected read data into exp_q.
// - At each falling edge, a monitor pops exp_q and compares DATA_OUT against
//   it. The monitor also checks EMPTY, FULL and COUNT against the model
//   occupancy.

module tb_simple_linear_fifo_core;

  localparam int DW    = 8;
  localparam int DEPTH = 16;
  localparam int AW    = $clog2(DEPTH);

  logic          FCLK;
  logic          FRSTN;
  logic          WR_EN;
  logic          RD_EN;
  logic [DW-1:0] DATA_IN;
  logic [DW-1:0] DATA_OUT;
  logic          EMPTY;
  logic          FULL;
`ifdef FIFO_COUNT_EN
  logic [AW:0]   COUNT;
`endif

  simple_linear_fifo_core #(
    .DATA_WIDTH(DW),
    .FIFO_DEPTH(DEPTH)
  ) dut (
    .FCLK    (FCLK),
    .FRSTN   (FRSTN),
    .WR_EN   (WR_EN),
    .RD_EN   (RD_EN),
    .DATA_IN (DATA_IN),
    .DATA_OUT(DATA_OUT),
    .EMPTY   (EMPTY),
`ifdef FIFO_COUNT_EN
    .COUNT   (COUNT),
`endif
    .FULL    (FULL)
  );

  // ---------------------------------------------------------------------
  // Clock and reset
  // ---------------------------------------------------------------------
  initial begin
    FCLK = 1'b0;
    forever #5 FCLK = ~FCLK;
  end

  // ---------------------------------------------------------------------
  // Reference model and scoreboard
  // ---------------------------------------------------------------------
  logic [DW-1:0] model_q[$];  // words currently stored in the FIFO
  logic [DW-1:0] exp_q[$];    // expected DATA_OUT values, one per output event
  logic [DW-1:0] last_out;    // value DATA_OUT must hold between reads
  bit            inited = 0;
  int            n_checks = 0;
  int            n_errors = 0;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s at t=%0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // The model samples the inputs at the rising edge. A reset clears the
  // model and sets DATA_OUT to zero. Otherwise a read pops the head and a
  // write appends to the tail. Both accept decisions use the occupancy
  // from before the edge.
  initial begin
    bit rd_ok, wr_ok;
    forever begin
      @(posedge FCLK);
      if (FRSTN === 1'b1) begin
        model_q.delete();
        exp_q.delete();
        exp_q.push_back('0);
        inited = 1;
      end else if (inited) begin
        rd_ok = (RD_EN === 1'b1) && (model_q.size() > 0);
        wr_ok = (WR_EN === 1'b1) && (model_q.size() < DEPTH);
        if (rd_ok) exp_q.push_back(model_q.pop_front());
        if (wr_ok) model_q.push_back(DATA_IN);
      end
    end
  end

  // Monitor
  initial begin
    logic [DW-1:0] e;
    forever begin
      @(negedge FCLK);
      if (inited) begin
        if (exp_q.size() > 0) begin
          e        = exp_q.pop_front();
          last_out = e;
          check("rd_data", 32'(DATA_OUT), 32'(e));
        end else begin
          check("hold", 32'(DATA_OUT), 32'(last_out));
        end
        check("empty", 32'(EMPTY), 32'(model_q.size() == 0));
        check("full",  32'(FULL),  32'(model_q.size() == DEPTH));
`ifdef FIFO_COUNT_EN
        check("count", 32'(COUNT), 32'(model_q.size()));
`endif
      end
    end
  end

  // ---------------------------------------------------------------------
  // Driver
  // ---------------------------------------------------------------------
  // Inputs are set after a falling edge and stay stable across the next
  // rising edge.
  task automatic drive(input logic rst, input logic w, input logic r,
                       input logic [DW-1:0] d);
    FRSTN   = rst;
    WR_EN   = w;
    RD_EN   = r;
    DATA_IN = d;
    @(negedge FCLK);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 1'b0, '0);
  endtask

  task automatic wr(input logic [DW-1:0] d);
    drive(1'b0, 1'b1, 1'b0, d);
  endtask

  task automatic rd();
    drive(1'b0, 1'b0, 1'b1, '0);
  endtask

  initial begin
    FRSTN   = 1'b0;
    WR_EN   = 1'b0;
    RD_EN   = 1'b0;
    DATA_IN = '0;

    // Reset pulse from t=10 to t=20, then idle until t=200.
    #10 FRSTN = 1'b1;
    @(negedge FCLK);
    FRSTN = 1'b0;
    while ($time < 200) @(negedge FCLK);

    // FIFO order.
    wr(8'h11); wr(8'h22); wr(8'h33);
    rd(); rd(); rd();
    idle(2);

    // Fill, overflow, drain. The 0xAA write arrives while FULL and must be
    // dropped.
    for (int i = 0; i < DEPTH; i++) wr(8'($urandom_range(0, 255)));
    wr(8'hAA);
    drive(1'b0, 1'b1, 1'b1, 8'hAA);  // full: only the read is accepted
    for (int i = 0; i < DEPTH; i++) rd();
    idle(1);

    // Underflow reads hold DATA_OUT.
    rd(); rd(); rd();
    // Empty: only the write is accepted.
    drive(1'b0, 1'b1, 1'b1, 8'h5C);
    rd();
    idle(1);

    // Concurrent read and write with 4 entries stored, run long enough for
    // the pointers to wrap.
    for (int i = 0; i < 4; i++) wr(8'($urandom_range(0, 255)));
    for (int i = 0; i < 20; i++) drive(1'b0, 1'b1, 1'b1, 8'($urandom_range(0, 255)));
    for (int i = 0; i < 4; i++) rd();
    idle(1);

    // Mid-operation reset with 5 entries stored.
    for (int i = 0; i < 5; i++) wr(8'($urandom_range(0, 255)));
    drive(1'b1, 1'b0, 1'b0, '0);
    wr(8'h3C); wr(8'hC3);
    rd(); rd(); rd();
    idle(1);

    // Random traffic. Each segment biases toward writes or toward reads so
    // that both the full and empty regions are visited. Resets are rare.
    for (int seg = 0; seg < 8; seg++) begin
      int wp;
      int rp;
      wp = (seg % 2 == 0) ? 80 : 25;
      rp = (seg % 2 == 0) ? 25 : 80;
      for (int i = 0; i < 60; i++) begin
        drive(1'($urandom_range(0, 299) == 0),
              1'($urandom_range(0, 99) < wp),
              1'($urandom_range(0, 99) < rp),
              8'($urandom_range(0, 255)));
      end
    end
    while (model_q.size() > 0) rd();
    idle(3);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
